// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Minimum bit width able to count 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n:0]   i_a,
    input  logic [n-1:0] i_q,
    input  logic [n-1:0] i_d,
    output logic [n:0]   o_a,
    output logic [n-1:0] o_q
);

    logic [n:0] w_a_sh;
    logic [n:0] w_t;
    logic       w_unused;

    // A never carries a set sign bit into a step, so only its low n bits shift up.
    assign w_unused = i_a[n];
    assign w_a_sh   = {i_a[n-1:0], i_q[n-1]};
    assign w_t      = w_a_sh - {1'b0, i_d};
    assign o_a      = w_t[n] ? w_a_sh : w_t;
    assign o_q      = {i_q[n-2:0], ~w_t[n]};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_divider
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = clog2(n);

    state_t         r_state;
    state_t         w_next;
    logic [n:0]     r_a;
    logic [n-1:0]   r_q;
    logic [n-1:0]   r_d;
    logic [CW-1:0]  r_cnt;
    logic [n-1:0]   r_quot;
    logic [n-1:0]   r_rem;
    logic           r_dbz;
    logic [n:0]     w_a_nxt;
    logic [n-1:0]   w_q_nxt;
    logic           w_accept;
    logic           w_zero;
    logic           w_last;

    div_step #(.n(n)) u_step (
        .i_a (r_a),
        .i_q (r_q),
        .i_d (r_d),
        .o_a (w_a_nxt),
        .o_q (w_q_nxt)
    );

    assign w_accept = start && (r_state != RUN);
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_state == RUN) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = w_zero ? DONE : RUN;
                end else if (r_state == DONE) begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state == RUN);
        done        = (r_state == DONE);
        quotient    = r_quot;
        remainder   = r_rem;
        div_by_zero = r_dbz;
    end

    // Results are only written on the edge that enters DONE, so they stay stable between operations.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_q   <= dividend;
            r_d   <= divisor;
            r_cnt <= CW'(n - 1);
            if (w_zero) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_quot <= w_q_nxt;
                r_rem  <= w_a_nxt[n-1:0];
                r_dbz  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (n=8)
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    seq_divider #(.n(N)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.lat = edbz ? 1 : N + 1;
        sb.push_back(e);
    endtask

    // Waits for done (called at a negedge), optionally pulsing a stray start mid-run.
    task automatic wait_done(input int inj_at, input logic [N-1:0] inj_a, input logic [N-1:0] inj_b);
        exp_t e;
        int   lat;
        int   busy_cyc;
        bit   ok;
        lat = 0;
        busy_cyc = 0;
        ok = 0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        repeat (40) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_cyc++;
            if (done) begin
                ok = 1;
                break;
            end
            if (lat == inj_at) begin
                start    = 1'b1;
                dividend = inj_a;
                divisor  = inj_b;
            end
        end
        check("done_seen", 32'(ok), 1);
        if (ok) begin
            check("latency", lat, e.lat);
            check("busy_cycles", busy_cyc, e.dbz ? 0 : N);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dbz);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [15:0]  prod;
        bit           seen;

        tbl[0]  = '{8'd56,  8'd7,   8'd8,   8'd0,   1'b0};
        tbl[1]  = '{8'd84,  8'd7,   8'd12,  8'd0,   1'b0};
        tbl[2]  = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
        tbl[3]  = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1};
        tbl[4]  = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0};
        tbl[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        tbl[6]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        tbl[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        tbl[8]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
        tbl[9]  = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
        tbl[10] = '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0};
        tbl[11] = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0};
        tbl[12] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            start_op(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].dbz);
            wait_done(0, '0, '0);
            @(negedge clk);
            check("done_single_pulse", done, 0);
            check("quotient_held", quotient, tbl[i].q);
        end

        // Back-to-back: second start issued in the done cycle of the first.
        start_op(8'd84, 8'd7, 8'd12, 8'd0, 1'b0);
        wait_done(0, '0, '0);
        start_op(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
        wait_done(0, '0, '0);
        @(negedge clk);

        // Stray start while busy must be ignored.
        start_op(8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
        wait_done(4, 8'd100, 8'd3);
        @(negedge clk);
        check("ignored_no_busy", busy, 0);
        check("ignored_no_done", done, 0);

        // Reset mid-run abandons the operation.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd9;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("midrst_no_activity", 32'(seen), 0);
        start_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        wait_done(0, '0, '0);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0: a = 8'd0;
                1: a = 8'd1;
                2: a = 8'd255;
                default: a = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 7))
                0: b = 8'd0;
                1: b = 8'd1;
                2: b = 8'd255;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (b == 0) start_op(a, b, 8'd255, a, 1'b1);
            else        start_op(a, b, a / b, a % b, 1'b0);
            wait_done(0, '0, '0);
            if (b != 0) begin
                prod = 16'(quotient) * 16'(b) + 16'(remainder);
                check("identity", prod, 16'(a));
                check("rem_lt_divisor", 32'(remainder < b), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
